// File: rtl/btn_pulse_sched.sv
// Debounced button edges, latched as pending requests and granted one at a time over valid/ready.
// Round-robin by default; defining SCHED_FIXED_PRIO_EN selects fixed lowest-index priority.
module btn_pulse_sched #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int HOLDOFF = 3
) (
  input  logic             clk,
  input  logic             clear_in,
  input  logic             tick,
  input  logic [N_REQ-1:0] req_in,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic [N_REQ-1:0] overflow
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] s0, s1;
  logic [N_REQ-1:0] pending, pending_nxt, overflow_nxt;
  logic [N_REQ-1:0] rise, clr_vec, ovf_set;
  logic [3:0]       hold_cnt, hold_cnt_nxt;
  logic             valid_nxt, hs;
  logic [IDX_W-1:0] idx_nxt, win_idx, idx_inc;

  function automatic logic [IDX_W-1:0] lowest(input logic [N_REQ-1:0] v);
    lowest = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (v[k]) lowest = IDX_W'(k);
    end
  endfunction

  // The oldest sample never feeds the qualifier, so only two sample stages are kept.
  assign rise    = {N_REQ{tick}} & req_in & s0 & ~s1;
  assign hs      = out_valid & out_ready;
  assign clr_vec = hs ? (N_REQ'(1) << out_idx) : '0;
  assign ovf_set = rise & pending & ~clr_vec;

  assign pending_nxt  = (pending & ~clr_vec) | rise;
  assign overflow_nxt = (clr_ovf ? '0 : overflow) | ovf_set;
  assign idx_inc      = (out_idx == IDX_W'(N_REQ - 1)) ? '0 : out_idx + IDX_W'(1);

`ifdef SCHED_FIXED_PRIO_EN
  assign win_idx = lowest(pending);
`else
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [N_REQ-1:0] hi_mask, masked;

  // Channels at or above the pointer win first; otherwise wrap to the lowest pending.
  assign hi_mask = {N_REQ{1'b1}} << rr_ptr;
  assign masked  = pending & hi_mask;
  assign win_idx = (|masked) ? lowest(masked) : lowest(pending);
`endif

  always_comb begin
    state_nxt    = state;
    valid_nxt    = out_valid;
    idx_nxt      = out_idx;
    hold_cnt_nxt = hold_cnt;
`ifndef SCHED_FIXED_PRIO_EN
    rr_nxt       = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (|pending) begin
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          valid_nxt = 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
          rr_nxt    = idx_inc;
`endif
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            hold_cnt_nxt = HOLD_LOAD;
            state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == 4'd0) state_nxt = IDLE;
        else                  hold_cnt_nxt = hold_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clear_in) begin
      s0        <= '0;
      s1        <= '0;
      pending   <= '0;
      overflow  <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      if (tick) begin
        s1 <= s0;
        s0 <= req_in;
      end
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      hold_cnt  <= hold_cnt_nxt;
      out_valid <= valid_nxt;
      out_idx   <= idx_nxt;
      busy      <= (state_nxt != IDLE);
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr    <= rr_nxt;
`endif
    end
  end

  // idx_inc is only consumed by the round-robin pointer.
`ifdef SCHED_FIXED_PRIO_EN
  logic unused_idx_inc;
  assign unused_idx_inc = ^idx_inc;
`endif

endmodule

// File: doc/btn_pulse_sched.md
Name: btn_pulse_sched

Overview:
- Front-end scheduler for the Basys3 pattern-recognition datapath.
- Conditions N raw button levels into debounced rising-edge events, using a three-sample "low, high, high" qualifier per channel.
- Latches events as pending requests and arbitrates them round-robin onto a single valid/ready symbol channel that feeds the sequence-detector FSM.
- Enforces a hold-off gap between grants so the detector sees at most one symbol per window.

Parameters:
- N_REQ, 4, number of button channels (2..8).
- IDX_W, 2, width of out_idx; must satisfy 2**IDX_W >= N_REQ.
- HOLDOFF, 3, idle clk cycles inserted after each accepted symbol (0..15; 0 = none).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clear_in  input  1  synchronous, active-high reset.
- tick  input  1  sample strobe from the clock divider; one clk wide.
- req_in  input  N_REQ  raw button levels, asynchronous to clk.
- out_ready  input  1  detector accepts symbol.
- clr_ovf  input  1  clears the overflow flags.
- out_valid  output  1  symbol available.
- out_idx  output  IDX_W  channel index of the granted symbol.
- busy  output  1  FSM not in IDLE.
- overflow  output  N_REQ  sticky per-channel lost-event flags.

Behaviour:
- One clock domain (clk); reset is synchronous, active-high on clear_in.
- Reset values: out_valid=0, out_idx=0, busy=0, overflow=0, pending=0, all sample registers 0, rr pointer=0, hold counter=0, state=IDLE.
- Reset asserted mid-GRANT or mid-HOLD: out_valid=0 on the next cycle and the pending event is discarded.
- Sampling, per channel i, only on cycles with tick=1: s2<=s1, s1<=s0, s0<=req_in[i]. With tick=0 the sample registers hold.
- Edge qualify: edge[i] = tick & req_in[i] & s0 & ~s1, evaluated on pre-shift values, i.e. the new window is low,high,high.
- Result: at most one edge per press; glitches shorter than 2 ticks are rejected.
- Pending: on edge[i], pending[i] is set on the same clk edge. It is visible the cycle after the qualifying tick.
- Overflow: edge[i] while pending[i]=1 and pending[i] is not being cleared that cycle sets overflow[i]. The event is dropped.
- Simultaneous edge[i] and handshake clear of channel i: pending[i] stays 1; overflow is not set.
- clr_ovf=1 clears overflow. An overflow set in the same cycle wins over the clear.
- Arbitration: round-robin starting at the rr pointer, searching upward with wrap to 0.
  - rr pointer <= granted idx + 1, with wrap from N_REQ-1 to 0, on each accepted symbol.
- FSM IDLE:
  - If any pending, latch the winner into out_idx, set out_valid=1, go to GRANT.
  - Latency: out_valid is high one cycle after pending becomes visible.
- FSM GRANT:
  - out_valid and out_idx stay stable until out_ready=1. A new pending channel must not alter out_idx.
  - On handshake (out_valid & out_ready): clear pending[out_idx] and drop out_valid on the next cycle.
  - Then: if HOLDOFF=0, go to IDLE; otherwise load the hold counter with HOLDOFF-1 and go to HOLD.
- FSM HOLD: decrement the counter each cycle; at 0, go to IDLE. No grant is issued in HOLD.
- Spacing: minimum accepted-symbol spacing is HOLDOFF+2 cycles with out_ready tied high.
- busy = (state != IDLE), registered.
- Pending requests persist indefinitely while out_ready=0. No starvation: every pending channel is granted within N_REQ handshakes.

Optional Feature:
- SCHED_FIXED_PRIO_EN defined: the arbiter ignores the rr pointer and always grants the lowest-index pending channel. The pointer register is removed.
- SCHED_FIXED_PRIO_EN undefined: round-robin as specified above.

Test Plan:
- Reset/idle: clear_in=1 for 2 cycles with req_in=4'b1111 -> all outputs 0, no out_valid for 3 subsequent ticks unless the low,high,high pattern occurs.
- Debounce: req_in[2] high for 1 tick then low -> no out_valid. High for 2+ ticks -> single out_valid with out_idx=2; holding high 20 ticks gives no second event.
- Round-robin: pend ch0,1,3 together, out_ready=1, HOLDOFF=3 -> out_idx sequence 0,1,3, accepted symbols 5 cycles apart. Then pend ch0 and ch1 -> 0,1 (pointer wrapped past 3); with SCHED_FIXED_PRIO_EN, same order 0,1.
- Backpressure/overflow: out_ready=0, two qualified presses on ch1 -> out_idx=1 held stable, overflow=4'b0010. clr_ovf -> overflow=0. Raise out_ready -> one handshake, pending[1]=0.
- Same-cycle clear and edge: an edge on ch2 coinciding with its handshake -> overflow[2]=0 and a second ch2 grant after the hold-off.
- Reset mid-grant: clear_in asserted while in GRANT -> out_valid=0 and busy=0 the next cycle, pending=0.
